// File: rtl/register_mask_encoder.sv
// Captures a 32-bit register-select mask and hands out one register number per accepted handshake.
// Optional macro SKIP_R0_EN drops bit 0 of the mask at capture so register 0 is never emitted.
module register_mask_encoder #(
  parameter int LSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] mask_in,
  input  logic        ready,
  output logic        valid,
  output logic [4:0]  reg_index,
  output logic [5:0]  remaining,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pending;
  logic [31:0] captured;
  logic [31:0] select_onehot;
  logic [31:0] pending_next;
  logic [4:0]  select;

  function automatic logic [4:0] select_index(input logic [31:0] bits);
    // NOTE: blocking assignments inside functions and always_comb; the last match wins the priority.
    logic [4:0] idx;
    idx = '0;
    if (LSB_FIRST != 0) begin
      for (int i = 31; i >= 0; i--)
        if (bits[i]) idx = 5'(i);
    end else begin
      for (int i = 0; i < 32; i++)
        if (bits[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  function automatic logic [5:0] count_ones(input logic [31:0] bits);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++)
      cnt = cnt + 6'(bits[i]);
    return cnt;
  endfunction

`ifdef SKIP_R0_EN
  assign captured = {mask_in[31:1], 1'b0};
`else
  assign captured = mask_in;
`endif

  assign select        = select_index(pending);
  assign select_onehot = 32'h1 << select;
  assign pending_next  = pending & ~select_onehot;
  assign reg_index     = valid ? select : 5'd0;

  // NOTE: non-blocking assignments for every flop so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      remaining <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load) begin
            pending   <= captured;
            remaining <= count_ones(captured);
            busy      <= 1'b1;
            if (captured != '0) begin
              state <= SCAN;
              valid <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (ready) begin
            pending   <= pending_next;
            remaining <= remaining - 6'd1;
            if (pending_next == '0) begin
              state <= DONE;
              valid <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
          valid   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
